// File: rtl/param_memory_system.sv
// Parametrised DEPTH x WIDTH register-file memory with a registered read port
// and a sequential bulk-clear engine that zeroes one word per cycle.
//
// Ports:
//   clk    - system clock, all state updates on the rising edge
//   reset  - asynchronous, active-high reset (zeroes array, outputs, engine)
//   data   - write data
//   store  - write enable for word[addr] (ignored while clearing)
//   addr   - shared word select for write and read
//   clear  - level-sampled start of a bulk clear (acts only when idle)
//   memory - registered read data of word[addr]
//   busy   - high while the clear engine is running
module param_memory_system #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             store,
    input  logic [AW-1:0]    addr,
    input  logic             clear,
    output logic [WIDTH-1:0] memory,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // One extra bit so DEPTH itself is representable in the range check.
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [AW-1:0]    ptr;
    logic [WIDTH-1:0] words [DEPTH];
    logic             in_range;

    // Addresses past DEPTH-1 exist only when DEPTH is not a power of two.
    assign in_range = ({1'b0, addr} < DEPTH_W);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (clear) begin
                    state_nx = CLEAR;
                end
            end
            CLEAR: begin
                if (ptr == LAST) begin
                    state_nx = IDLE;
                end
            end
        endcase
    end

    // busy is driven directly from the state register, so it is glitch-free.
    always_comb begin
        busy = (state == CLEAR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                words[i] <= '0;
            end
            ptr    <= '0;
            memory <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // A starting clear takes priority over a same-cycle store.
                    if (store && in_range && !clear) begin
                        words[addr] <= data;
                    end
                    if (clear || !in_range) begin
                        memory <= '0;
                    end else if (store) begin
                        memory <= data;
                    end else begin
                        memory <= words[addr];
                    end
                end
                CLEAR: begin
                    words[ptr] <= '0;
                    ptr        <= (ptr == LAST) ? '0 : ptr + 1'b1;
                    memory     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_memory_system.sv
// Directed bench for param_memory_system: a 4x8 instance and a 5x12 instance
// checked against hand-computed values with immediate assertions.
module tb_param_memory_system;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [7:0]  a_data = '0;
    logic        a_store = 1'b0;
    logic [1:0]  a_addr = '0;
    logic        a_clear = 1'b0;
    logic [7:0]  a_memory;
    logic        a_busy;

    logic [11:0] b_data = '0;
    logic        b_store = 1'b0;
    logic [2:0]  b_addr = '0;
    logic        b_clear = 1'b0;
    logic [11:0] b_memory;
    logic        b_busy;

    int checks = 0;
    int errors = 0;
    int cnt;

    always #5 clk = ~clk;

    param_memory_system #(.WIDTH(8), .DEPTH(4)) dut_a (
        .clk    (clk),
        .reset  (reset),
        .data   (a_data),
        .store  (a_store),
        .addr   (a_addr),
        .clear  (a_clear),
        .memory (a_memory),
        .busy   (a_busy)
    );

    param_memory_system #(.WIDTH(12), .DEPTH(5)) dut_b (
        .clk    (clk),
        .reset  (reset),
        .data   (b_data),
        .store  (b_store),
        .addr   (b_addr),
        .clear  (b_clear),
        .memory (b_memory),
        .busy   (b_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic a_write(input logic [1:0] ad, input logic [7:0] d);
        a_store = 1'b1;
        a_addr  = ad;
        a_data  = d;
        tick();
        a_store = 1'b0;
    endtask

    task automatic a_read(input string tag, input logic [1:0] ad,
                          input logic [7:0] exp);
        a_addr = ad;
        tick();
        check(tag, 32'(a_memory), 32'(exp));
    endtask

    task automatic b_read(input string tag, input logic [2:0] ad,
                          input logic [11:0] exp);
        b_addr = ad;
        tick();
        check(tag, 32'(b_memory), 32'(exp));
    endtask

    initial begin
        // Reset held from time 0
        tick();
        tick();
        check("rst_mem", 32'(a_memory), 32'h0);
        check("rst_busy", 32'(a_busy), 32'h0);
        reset = 1'b0;
        tick();

        // Write with write-first read data
        a_write(2'd0, 8'hA5);
        check("wr0_mem", 32'(a_memory), 32'hA5);
        a_write(2'd1, 8'h3C);
        check("wr1_mem", 32'(a_memory), 32'h3C);
        a_write(2'd2, 8'hFF);
        check("wr2_mem", 32'(a_memory), 32'hFF);
        a_write(2'd3, 8'h01);
        check("wr3_mem", 32'(a_memory), 32'h01);

        // Read back
        a_read("rd0", 2'd0, 8'hA5);
        a_read("rd1", 2'd1, 8'h3C);
        a_read("rd2", 2'd2, 8'hFF);
        a_read("rd3", 2'd3, 8'h01);

        // Write-first over existing 0xFF
        a_write(2'd2, 8'h77);
        check("wfirst", 32'(a_memory), 32'h77);
        a_read("wfirst_rd", 2'd2, 8'h77);

        // Asynchronous reset mid-cycle while memory is non-zero
        #2;
        reset = 1'b1;
        #1;
        check("async_mem", 32'(a_memory), 32'h0);
        check("async_busy", 32'(a_busy), 32'h0);
        tick();
        reset = 1'b0;
        a_read("post_rst0", 2'd0, 8'h0);
        a_read("post_rst1", 2'd1, 8'h0);
        a_read("post_rst2", 2'd2, 8'h0);
        a_read("post_rst3", 2'd3, 8'h0);

        // Bulk clear with a stray store while busy
        a_write(2'd0, 8'h11);
        a_write(2'd1, 8'h22);
        a_write(2'd2, 8'h33);
        a_write(2'd3, 8'h44);
        a_addr  = 2'd3;
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        cnt = 0;
        while (a_busy && cnt < 20) begin
            cnt++;
            check("clr_mem", 32'(a_memory), 32'h0);
            // word[0] is already zeroed by now, so a leaked store would show
            a_store = (cnt == 3);
            a_addr  = 2'd0;
            a_data  = 8'h99;
            tick();
        end
        a_store = 1'b0;
        check("clr_busy_len", 32'(cnt), 32'd4);
        check("clr_exit_mem", 32'(a_memory), 32'h0);
        a_read("clr_rd0", 2'd0, 8'h0);
        a_read("clr_rd1", 2'd1, 8'h0);
        a_read("clr_rd2", 2'd2, 8'h0);
        a_read("clr_rd3", 2'd3, 8'h0);

        // Clear and store in the same idle cycle
        a_write(2'd1, 8'h66);
        a_clear = 1'b1;
        a_store = 1'b1;
        a_addr  = 2'd1;
        a_data  = 8'h55;
        tick();
        a_clear = 1'b0;
        a_store = 1'b0;
        check("cs_busy", 32'(a_busy), 32'h1);
        check("cs_mem", 32'(a_memory), 32'h0);
        cnt = 0;
        while (a_busy && cnt < 20) begin
            cnt++;
            tick();
        end
        check("cs_busy_len", 32'(cnt), 32'd4);
        a_read("cs_rd1", 2'd1, 8'h0);

        // Reset during a clear aborts it
        a_write(2'd2, 8'h5A);
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        tick();
        check("rc_busy_pre", 32'(a_busy), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("rc_busy", 32'(a_busy), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        check("rc_idle", 32'(a_busy), 32'h0);
        a_read("rc_rd2", 2'd2, 8'h0);
        a_write(2'd3, 8'hC3);
        a_read("rc_rd3", 2'd3, 8'hC3);

        // Non-power-of-two depth instance
        for (int i = 0; i < 4; i++) begin
            b_store = 1'b1;
            b_addr  = 3'(i);
            b_data  = 12'(12'h100 + i);
            tick();
        end
        b_addr = 3'd4;
        b_data = 12'hABC;
        tick();
        check("b_wr4", 32'(b_memory), 32'hABC);
        b_addr = 3'd6;
        b_data = 12'h123;
        tick();
        check("b_wr6", 32'(b_memory), 32'h0);
        b_addr = 3'd7;
        b_data = 12'h456;
        tick();
        check("b_wr7", 32'(b_memory), 32'h0);
        b_store = 1'b0;
        b_read("b_rd4", 3'd4, 12'hABC);
        b_read("b_rd6", 3'd6, 12'h0);
        b_read("b_rd7", 3'd7, 12'h0);
        b_read("b_rd0", 3'd0, 12'h100);
        b_read("b_rd1", 3'd1, 12'h101);
        b_read("b_rd2", 3'd2, 12'h102);
        b_read("b_rd3", 3'd3, 12'h103);

        b_clear = 1'b1;
        tick();
        b_clear = 1'b0;
        cnt = 0;
        while (b_busy && cnt < 20) begin
            cnt++;
            check("b_clr_mem", 32'(b_memory), 32'h0);
            tick();
        end
        check("b_clr_len", 32'(cnt), 32'd5);
        b_read("b_clr_rd4", 3'd4, 12'h0);
        b_read("b_clr_rd0", 3'd0, 12'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
